regfile_write_port: RTL and testbench

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/regfile_write_port.sv | 91 +++++++++
 tb/tb_regfile_write_port.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// Register-file write port: buffers write requests in a small FIFO, retires them
// one per permitted cycle as a registered one-hot write, and forwards pending data.
module regfile_write_port #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        drain_en,
    output logic [31:0] wr_onehot,
    output logic [31:0] wr_data,
    input  logic [4:0]  rd_addr,
    output logic        byp_hit,
    output logic [31:0] byp_data,
    output logic        idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] idx;
    logic          push;
    logic          pop;

    assign in_ready = reset_n && (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = drain_en && (count != '0);
    assign idle     = (count == '0) && (wr_onehot == '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_onehot <= '0;
            wr_data   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Register zero is hardwired, so its writes are dropped at retirement.
            wr_onehot <= '0;
            if (pop && (addr_q[rd_ptr] != 5'd0)) begin
                wr_onehot <= 32'd1 << addr_q[rd_ptr];
                wr_data   <= data_q[rd_ptr];
            end
        end
    end

    // Entry storage needs no reset: push is already blocked while reset_n is low.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
    end

    // Scan oldest to youngest so that the last match (the youngest) wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        idx      = '0;
        if (rd_addr != 5'd0) begin
            if (wr_onehot[rd_addr]) begin
                byp_hit  = 1'b1;
                byp_data = wr_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count) && (addr_q[idx] == rd_addr)) begin
                    byp_hit  = 1'b1;
                    byp_data = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: directed vectors push expected writes,
// an independent monitor checks every retired write in order.
module tb_regfile_write_port;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_en;
    logic [31:0] wr_onehot;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic        byp_hit;
    logic [31:0] byp_data;
    logic        idle;

    int   checks   = 0;
    int   failures = 0;
    int   mcount   = 0;
    ent_t expq[$];

    regfile_write_port #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .drain_en  (drain_en),
        .wr_onehot (wr_onehot),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data),
        .idle      (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model across the edge.
    task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d, input logic dr);
        bit mpush;
        bit mpop;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        drain_en = dr;
        #1;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (reset_n && mcount != DEPTH)});
        if (!reset_n) begin
            mcount = 0;
            expq.delete();
        end else begin
            mpush = v && (mcount != DEPTH);
            mpop  = dr && (mcount != 0);
            mcount = mcount + int'(mpush) - int'(mpop);
            if (mpush && a != 5'd0) expq.push_back('{addr: a, data: d});
        end
        @(negedge clock);
    endtask

    // Monitor: every nonzero write enable must match the oldest expected write.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (reset_n && wr_onehot != 32'd0) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got onehot 0x%08h data 0x%08h expected no write", wr_onehot, wr_data);
                end else begin
                    e = expq.pop_front();
                    checkOutput("mon_onehot", wr_onehot, 32'd1 << e.addr);
                    checkOutput("mon_data", wr_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b0;
        rd_addr  = '0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("ready_in_reset", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_idle", {31'd0, idle}, 32'd1);
        checkOutput("reset_byp_hit", {31'd0, byp_hit}, 32'd0);
        checkOutput("reset_byp_data", byp_data, 32'd0);
        checkOutput("reset_onehot", wr_onehot, 32'd0);

        // Single write, also no pass-through from an empty buffer
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        checkOutput("no_passthru", wr_onehot, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("single_onehot", wr_onehot, 32'h0000_0020);
        checkOutput("single_data", wr_data, 32'hDEADBEEF);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("single_clear", wr_onehot, 32'd0);
        checkOutput("single_hold", wr_data, 32'hDEADBEEF);
        checkOutput("single_idle", {31'd0, idle}, 32'd1);

        // Register zero is discarded and never bypassed
        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0);
        rd_addr = 5'd0;
        #1;
        checkOutput("r0_byp_hit", {31'd0, byp_hit}, 32'd0);
        checkOutput("r0_idle_pending", {31'd0, idle}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("r0_onehot", wr_onehot, 32'd0);
        checkOutput("r0_data_hold", wr_data, 32'hDEADBEEF);
        checkOutput("r0_idle", {31'd0, idle}, 32'd1);

        // Fill to DEPTH, fifth request refused, then drain in order
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1'b0);
        checkOutput("full_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("fill_idle", {31'd0, idle}, 32'd1);

        // Bypass: youngest pending write wins, output stage is oldest
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b0);
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b0);
        rd_addr = 5'd7;
        #1;
        checkOutput("byp_hit7", {31'd0, byp_hit}, 32'd1);
        checkOutput("byp_data7", byp_data, 32'h22);
        rd_addr = 5'd8;
        #1;
        checkOutput("byp_hit8", {31'd0, byp_hit}, 32'd0);
        checkOutput("byp_data8", byp_data, 32'd0);
        rd_addr = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("byp_mixed", byp_data, 32'h22);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("byp_outstage_hit", {31'd0, byp_hit}, 32'd1);
        checkOutput("byp_outstage_data", byp_data, 32'h22);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("byp_gone", {31'd0, byp_hit}, 32'd0);

        // Steady push+pop at two entries across pointer wrap
        applyStimulus(1'b1, 5'd3, 32'hB0, 1'b0);
        applyStimulus(1'b1, 5'd4, 32'hB1, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 5'(10 + i), 32'hC0 + 32'(i), 1'b1);
        checkOutput("wrap_count", mcount, 32'd2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("wrap_idle", {31'd0, idle}, 32'd1);

        // Reset with three pending entries drops them all
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 5'(20 + i), 32'hD0 + 32'(i), 1'b0);
        reset_n = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'hEE, 1'b1);
        reset_n = 1'b1;
        #1;
        checkOutput("rst_onehot", wr_onehot, 32'd0);
        checkOutput("rst_idle", {31'd0, idle}, 32'd1);
        applyStimulus(1'b1, 5'd12, 32'hF00D, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("post_rst_idle", {31'd0, idle}, 32'd1);

        checkOutput("scoreboard_empty", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
